// File: rtl/seq_lock_pkg.sv
// Shared encodings and sizing helpers for the two-button combination lock controller.
// State values match the software-visible encoding of the state output.
package seq_lock_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ARMED    = 2'd0;
    localparam logic [STATE_W-1:0] ENTRY    = 2'd1;
    localparam logic [STATE_W-1:0] UNLOCKED = 2'd2;
    localparam logic [STATE_W-1:0] LOCKOUT  = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        StArmed    = ARMED,
        StEntry    = ENTRY,
        StUnlocked = UNLOCKED,
        StLockout  = LOCKOUT
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_sym_arbiter.sv
// Turns debounced P1/P2 levels into mutually exclusive one-cycle symbol pulses.
// Ambiguous presses (simultaneous, or one while the other is held) raise sym_err instead.
module btn_sym_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic btn_p1,
    input  logic btn_p2,
    input  logic sym_en,
    output logic det_p1,
    output logic det_p2,
    output logic sym_err
);

    logic btn_p1_q, btn_p2_q;
    logic det_p1_q, det_p1_d;
    logic det_p2_q, det_p2_d;
    logic sym_err_q, sym_err_d;
    logic rise_p1, rise_p2;

    always_comb begin
        rise_p1   = btn_p1 & ~btn_p1_q;
        rise_p2   = btn_p2 & ~btn_p2_q;
        det_p1_d  = sym_en & rise_p1 & ~btn_p2;
        det_p2_d  = sym_en & rise_p2 & ~btn_p1;
        // Covers both the same-cycle case and a press while the other button is held
        sym_err_d = sym_en & ((rise_p1 & btn_p2) | (rise_p2 & btn_p1));
    end

    // Level history keeps tracking while disabled so a press held through
    // lockout does not turn into a symbol once the lock re-arms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p1_q  <= 1'b0;
            btn_p2_q  <= 1'b0;
            det_p1_q  <= 1'b0;
            det_p2_q  <= 1'b0;
            sym_err_q <= 1'b0;
        end else begin
            btn_p1_q  <= btn_p1;
            btn_p2_q  <= btn_p2;
            det_p1_q  <= det_p1_d;
            det_p2_q  <= det_p2_d;
            sym_err_q <= sym_err_d;
        end
    end

    assign det_p1  = det_p1_q;
    assign det_p2  = det_p2_q;
    assign sym_err = sym_err_q;

endmodule

// File: rtl/seq_lock_ctrl.sv
// Combination-lock sequencer around seq_detector_mealy: symbol and failure counting,
// idle abort, and unlock / lockout-alarm timing from a single down-timer.
module seq_lock_ctrl
    import seq_lock_pkg::*;
#(
    parameter int unsigned SEQ_LEN     = 3,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned UNLOCK_CYC  = 8,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter int unsigned IDLE_TO     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_p1,
    input  logic               btn_p2,
    input  logic               det_z,
    output logic               det_p1,
    output logic               det_p2,
    output logic               det_rst,
    output logic               unlock,
    output logic               alarm,
    output logic               sym_err,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         fail_cnt
);

    localparam int unsigned TIMER_W = $clog2(max3(UNLOCK_CYC, LOCKOUT_CYC, IDLE_TO) + 1);
    localparam int unsigned SYM_W   = $clog2(SEQ_LEN + 1);

    // Loads are N-1 because the expiry decision is taken in the cycle the timer reads 0
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] IDLE_LOAD    = TIMER_W'(IDLE_TO - 1);
    localparam logic [SYM_W-1:0]   SYM_LAST     = SYM_W'(SEQ_LEN - 1);
    localparam logic [SYM_W-1:0]   SYM_ONE      = SYM_W'(1);
    localparam logic [1:0]         FAIL_SAT     = 2'(MAX_FAIL);

    state_e             state_q, state_d;
    logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [1:0]         fail_cnt_q, fail_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               det_rst_q, det_rst_d;
    logic               unlock_q, unlock_d;
    logic               alarm_q, alarm_d;
    logic               sym_en;
    logic               sym;
    logic [1:0]         fail_inc;

    assign sym_en = (state_q == StArmed) || (state_q == StEntry);

    btn_sym_arbiter u_arbiter (
        .clk     (clk),
        .reset   (reset),
        .btn_p1  (btn_p1),
        .btn_p2  (btn_p2),
        .sym_en  (sym_en),
        .det_p1  (det_p1),
        .det_p2  (det_p2),
        .sym_err (sym_err)
    );

    // det_z is only meaningful alongside a symbol pulse, so both are sampled together
    assign sym      = det_p1 | det_p2;
    assign fail_inc = (fail_cnt_q == FAIL_SAT) ? fail_cnt_q : fail_cnt_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StArmed;
            sym_cnt_q  <= '0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            det_rst_q  <= 1'b0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            det_rst_q  <= det_rst_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        unique case (state_q)
            StArmed: begin
                if (sym && det_z) begin
                    state_d    = StUnlocked;
                    sym_cnt_d  = '0;
                    fail_cnt_d = '0;
                    timer_d    = UNLOCK_LOAD;
                end else if (sym) begin
                    state_d   = StEntry;
                    sym_cnt_d = SYM_ONE;
                    timer_d   = IDLE_LOAD;
                end
            end
            StEntry: begin
                if (sym && det_z) begin
                    state_d    = StUnlocked;
                    sym_cnt_d  = '0;
                    fail_cnt_d = '0;
                    timer_d    = UNLOCK_LOAD;
                end else if (sym && (sym_cnt_q == SYM_LAST)) begin
                    sym_cnt_d  = '0;
                    fail_cnt_d = fail_inc;
                    if (fail_inc == FAIL_SAT) begin
                        state_d = StLockout;
                        timer_d = LOCKOUT_LOAD;
                    end else begin
                        state_d = StArmed;
                        timer_d = '0;
                    end
                end else if (sym) begin
                    sym_cnt_d = sym_cnt_q + SYM_ONE;
                    timer_d   = IDLE_LOAD;
                end else if (timer_q == '0) begin
                    state_d   = StArmed;
                    sym_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StUnlocked: begin
                if (timer_q == '0) begin
                    state_d = StArmed;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d    = StArmed;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StArmed;
            end
        endcase
    end

    // Detector restarts on every return to ARMED and on the failing symbol into lockout
    always_comb begin
        det_rst_d = ((state_q != StArmed) && (state_d == StArmed)) ||
                    ((state_q == StEntry) && (state_d == StLockout));
        unlock_d  = (state_d == StUnlocked);
        alarm_d   = (state_d == StLockout);
    end

    assign det_rst  = det_rst_q;
    assign unlock   = unlock_q;
    assign alarm    = alarm_q;
    assign state    = state_q;
    assign fail_cnt = fail_cnt_q;

    assert property (@(posedge clk) disable iff (reset) !(det_p1 && det_p2));
    assert property (@(posedge clk) disable iff (reset) !(unlock && alarm));
    assert property (@(posedge clk) disable iff (reset) fail_cnt_q <= FAIL_SAT);

endmodule
